// File: rtl/dtl_burst_master.sv
// Queued burst DTL master: an in-order command queue feeds a one-at-a-time
// DTL issuer. Write beats pass straight through to DTL, read beats pass
// straight back to the client, and a beat counter drives WriteLast and checks
// the slave's ReadLast.
module dtl_burst_master #(
  parameter int D_WIDTH     = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 5,
  parameter int QUEUE_DEPTH = 4,
  parameter int NUM_ENABLES = D_WIDTH / 8
) (
  input  logic                   iClk,
  input  logic                   iReset,
  // client request side
  input  logic                   iReqValid,
  output logic                   oReqAccept,
  input  logic                   iReqWrite,
  input  logic [ADDR_WIDTH-1:0]  iReqAddress,
  input  logic [BLOCK_WIDTH-1:0] iReqBlockSize,
  // client write stream
  input  logic [D_WIDTH-1:0]     iWriteData,
  input  logic [NUM_ENABLES-1:0] iWriteEnable,
  input  logic                   iWriteDataValid,
  output logic                   oWriteDataAccept,
  // client read stream
  output logic [D_WIDTH-1:0]     oReadData,
  output logic                   oReadDataValid,
  output logic                   oReadLast,
  input  logic                   iReadAccept,
  // status
  output logic                   oBusy,
  output logic                   oProtocolError,
  // DTL side
  input  logic                   iDTL_CommandAccept,
  input  logic                   iDTL_WriteAccept,
  input  logic                   iDTL_ReadValid,
  input  logic                   iDTL_ReadLast,
  input  logic [D_WIDTH-1:0]     iDTL_ReadData,
  output logic                   oDTL_CommandValid,
  output logic                   oDTL_CommandReadWrite,
  output logic [ADDR_WIDTH-1:0]  oDTL_Address,
  output logic [BLOCK_WIDTH-1:0] oDTL_BlockSize,
  output logic                   oDTL_WriteValid,
  output logic [D_WIDTH-1:0]     oDTL_WriteData,
  output logic [NUM_ENABLES-1:0] oDTL_WriteEnable,
  output logic                   oDTL_WriteLast,
  output logic                   oDTL_ReadAccept
);

  localparam int PTR_W   = $clog2(QUEUE_DEPTH);
  localparam int ENTRY_W = 1 + ADDR_WIDTH + BLOCK_WIDTH;
  localparam logic [PTR_W:0] Q_FULL = (PTR_W + 1)'(QUEUE_DEPTH);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  state_t                 state;
  logic [ENTRY_W-1:0]     qMem [QUEUE_DEPTH];
  logic [PTR_W-1:0]       wrPtr;
  logic [PTR_W-1:0]       rdPtr;
  logic [PTR_W:0]         qCount;

  logic                   cmdRead;
  logic [ADDR_WIDTH-1:0]  cmdAddress;
  logic [BLOCK_WIDTH-1:0] cmdBlockSize;
  logic [BLOCK_WIDTH-1:0] beatCount;
  logic                   protocolError;

  logic                   headWrite;
  logic [ADDR_WIDTH-1:0]  headAddress;
  logic [BLOCK_WIDTH-1:0] headBlockSize;

  logic inCmd, inWrite, inRead;
  logic writeBeat, readBeat, lastCount, burstDone;
  logic qNotEmpty, push, pop;

  assign {headWrite, headAddress, headBlockSize} = qMem[rdPtr];

  // Handshake and queue control decode
  always_comb begin
    inCmd     = (state == CMD);
    inWrite   = (state == WDATA);
    inRead    = (state == RDATA);
    qNotEmpty = (qCount != '0);
    lastCount = (beatCount == cmdBlockSize);
    writeBeat = inWrite & iWriteDataValid & iDTL_WriteAccept;
    readBeat  = inRead & iDTL_ReadValid & iReadAccept;
    burstDone = (writeBeat | readBeat) & lastCount;
    push      = iReqValid & oReqAccept;
    pop       = qNotEmpty & ((state == IDLE) | burstDone);
  end

  // Queue storage; entries are only meaningful between push and pop
  always_ff @(posedge iClk) begin
    if (push) qMem[wrPtr] <= {iReqWrite, iReqAddress, iReqBlockSize};
  end

  // Queue pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge iClk) begin
    if (iReset) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      qCount <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   qCount <= qCount + 1'b1;
        2'b01:   qCount <= qCount - 1'b1;
        default: ;
      endcase
    end
  end

  // Transaction sequencer: loads the queue head, issues the command, counts beats
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state         <= IDLE;
      cmdRead       <= 1'b0;
      cmdAddress    <= '0;
      cmdBlockSize  <= '0;
      beatCount     <= '0;
      protocolError <= 1'b0;
    end else begin
      if (readBeat && (iDTL_ReadLast != lastCount)) protocolError <= 1'b1;
      case (state)
        IDLE: begin
          if (pop) begin
            cmdRead      <= ~headWrite;
            cmdAddress   <= headAddress;
            cmdBlockSize <= headBlockSize;
            state        <= CMD;
          end
        end
        CMD: begin
          if (iDTL_CommandAccept) begin
            beatCount <= '0;
            state     <= cmdRead ? RDATA : WDATA;
          end
        end
        WDATA, RDATA: begin
          if (writeBeat || readBeat) begin
            beatCount <= beatCount + 1'b1;
            // burst ends on our own count, whatever the slave's ReadLast says
            if (lastCount) begin
              if (pop) begin
                cmdRead      <= ~headWrite;
                cmdAddress   <= headAddress;
                cmdBlockSize <= headBlockSize;
                state        <= CMD;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign oReqAccept            = (qCount < Q_FULL);
  assign oBusy                 = qNotEmpty | (state != IDLE);
  assign oProtocolError        = protocolError;

  assign oDTL_CommandValid     = inCmd;
  assign oDTL_CommandReadWrite = cmdRead;
  assign oDTL_Address          = cmdAddress;
  assign oDTL_BlockSize        = cmdBlockSize;

  assign oDTL_WriteValid       = inWrite & iWriteDataValid;
  assign oDTL_WriteData        = inWrite ? iWriteData : '0;
  assign oDTL_WriteEnable      = inWrite ? iWriteEnable : '0;
  assign oDTL_WriteLast        = inWrite & lastCount;
  assign oWriteDataAccept      = writeBeat;

  assign oReadDataValid        = inRead & iDTL_ReadValid;
  assign oReadData             = inRead ? iDTL_ReadData : '0;
  assign oReadLast             = inRead & lastCount;
  assign oDTL_ReadAccept       = inRead & iReadAccept;

endmodule

// File: tb/tb_dtl_burst_master.sv
// Scoreboard bench for dtl_burst_master: stimulus pushes expected DTL
// commands, write beats and read beats; negedge monitors pop and compare.
module tb_dtl_burst_master;

  logic        iClk = 1'b0;
  logic        iReset;
  logic        iReqValid, iReqWrite;
  logic [31:0] iReqAddress;
  logic [4:0]  iReqBlockSize;
  logic [31:0] iWriteData;
  logic [3:0]  iWriteEnable;
  logic        iWriteDataValid, iReadAccept;
  logic        iDTL_CommandAccept, iDTL_WriteAccept, iDTL_ReadValid, iDTL_ReadLast;
  logic [31:0] iDTL_ReadData;
  logic        oReqAccept, oWriteDataAccept, oReadDataValid, oReadLast, oBusy, oProtocolError;
  logic [31:0] oReadData;
  logic        oDTL_CommandValid, oDTL_CommandReadWrite, oDTL_WriteValid, oDTL_WriteLast, oDTL_ReadAccept;
  logic [31:0] oDTL_Address, oDTL_WriteData;
  logic [4:0]  oDTL_BlockSize;
  logic [3:0]  oDTL_WriteEnable;

  always #5 iClk = ~iClk;

  dtl_burst_master #(.D_WIDTH(32), .ADDR_WIDTH(32), .BLOCK_WIDTH(5), .QUEUE_DEPTH(4)) dut (
    .iClk(iClk), .iReset(iReset),
    .iReqValid(iReqValid), .oReqAccept(oReqAccept), .iReqWrite(iReqWrite),
    .iReqAddress(iReqAddress), .iReqBlockSize(iReqBlockSize),
    .iWriteData(iWriteData), .iWriteEnable(iWriteEnable),
    .iWriteDataValid(iWriteDataValid), .oWriteDataAccept(oWriteDataAccept),
    .oReadData(oReadData), .oReadDataValid(oReadDataValid), .oReadLast(oReadLast),
    .iReadAccept(iReadAccept), .oBusy(oBusy), .oProtocolError(oProtocolError),
    .iDTL_CommandAccept(iDTL_CommandAccept), .iDTL_WriteAccept(iDTL_WriteAccept),
    .iDTL_ReadValid(iDTL_ReadValid), .iDTL_ReadLast(iDTL_ReadLast), .iDTL_ReadData(iDTL_ReadData),
    .oDTL_CommandValid(oDTL_CommandValid), .oDTL_CommandReadWrite(oDTL_CommandReadWrite),
    .oDTL_Address(oDTL_Address), .oDTL_BlockSize(oDTL_BlockSize),
    .oDTL_WriteValid(oDTL_WriteValid), .oDTL_WriteData(oDTL_WriteData),
    .oDTL_WriteEnable(oDTL_WriteEnable), .oDTL_WriteLast(oDTL_WriteLast),
    .oDTL_ReadAccept(oDTL_ReadAccept)
  );

  typedef struct { logic rd; logic [31:0] addr; logic [4:0] size; } cmd_t;
  typedef struct { logic [31:0] data; logic [3:0] en; logic last; } wbeat_t;
  typedef struct { logic [31:0] data; logic last; } rbeat_t;

  cmd_t   expCmd[$];
  wbeat_t expW[$];
  rbeat_t expR[$];

  int vectors = 0;
  int miscompares = 0;
  int wAccepts = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Command monitor
  always @(negedge iClk) begin
    if (!iReset && oDTL_CommandValid && iDTL_CommandAccept) begin
      if (expCmd.size() == 0) check("unexpected_cmd", 64'd1, 64'd0);
      else begin
        cmd_t c;
        c = expCmd.pop_front();
        check("cmd_rw", {63'd0, oDTL_CommandReadWrite}, {63'd0, c.rd});
        check("cmd_addr", {32'd0, oDTL_Address}, {32'd0, c.addr});
        check("cmd_size", {59'd0, oDTL_BlockSize}, {59'd0, c.size});
      end
    end
  end

  // Write beat monitor
  always @(negedge iClk) begin
    if (!iReset && oWriteDataAccept) wAccepts++;
    if (!iReset && oDTL_WriteValid && iDTL_WriteAccept) begin
      if (expW.size() == 0) check("unexpected_wbeat", 64'd1, 64'd0);
      else begin
        wbeat_t w;
        w = expW.pop_front();
        check("wr_data", {32'd0, oDTL_WriteData}, {32'd0, w.data});
        check("wr_en", {60'd0, oDTL_WriteEnable}, {60'd0, w.en});
        check("wr_last", {63'd0, oDTL_WriteLast}, {63'd0, w.last});
        check("wr_accept", {63'd0, oWriteDataAccept}, 64'd1);
      end
    end
  end

  // Read beat monitor
  always @(negedge iClk) begin
    if (!iReset && oReadDataValid && iReadAccept) begin
      if (expR.size() == 0) check("unexpected_rbeat", 64'd1, 64'd0);
      else begin
        rbeat_t r;
        r = expR.pop_front();
        check("rd_data", {32'd0, oReadData}, {32'd0, r.data});
        check("rd_last", {63'd0, oReadLast}, {63'd0, r.last});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic idleInputs();
    iReqValid = 0; iReqWrite = 0; iReqAddress = '0; iReqBlockSize = '0;
    iWriteData = '0; iWriteEnable = '0; iWriteDataValid = 0; iReadAccept = 0;
    iDTL_CommandAccept = 0; iDTL_WriteAccept = 0; iDTL_ReadValid = 0;
    iDTL_ReadLast = 0; iDTL_ReadData = '0;
  endtask

  task automatic doReset();
    idleInputs();
    iReset = 1;
    tick(); tick();
    iReset = 0;
    check("rst_reqaccept", {63'd0, oReqAccept}, 64'd1);
    check("rst_busy", {63'd0, oBusy}, 64'd0);
    check("rst_cmdvalid", {63'd0, oDTL_CommandValid}, 64'd0);
    check("rst_rw", {63'd0, oDTL_CommandReadWrite}, 64'd0);
    check("rst_addr", {32'd0, oDTL_Address}, 64'd0);
    check("rst_size", {59'd0, oDTL_BlockSize}, 64'd0);
    check("rst_wvalid", {63'd0, oDTL_WriteValid}, 64'd0);
    check("rst_wlast", {63'd0, oDTL_WriteLast}, 64'd0);
    check("rst_rvalid", {63'd0, oReadDataValid}, 64'd0);
    check("rst_perr", {63'd0, oProtocolError}, 64'd0);
  endtask

  // One-cycle request; the caller is at posedge+1
  task automatic sendReq(input logic wr, input logic [31:0] addr, input logic [4:0] size);
    iReqValid = 1; iReqWrite = wr; iReqAddress = addr; iReqBlockSize = size;
    check("req_accept", {63'd0, oReqAccept}, 64'd1);
    expCmd.push_back('{rd: ~wr, addr: addr, size: size});
    tick();
    iReqValid = 0;
  endtask

  // Accept the next command, waiting a bounded number of cycles for it
  task automatic acceptCmd();
    int n;
    n = 0;
    while (!oDTL_CommandValid && n < 20) begin
      tick();
      n++;
    end
    if (!oDTL_CommandValid) check("cmd_timeout", 64'd0, 64'd1);
    else begin
      iDTL_CommandAccept = 1;
      tick();
      iDTL_CommandAccept = 0;
    end
  endtask

  // Stream n beats of a burst of 'total'; DTL stalls once before beat 'stallIdx'
  task automatic writeBeats(input int n, input int total, input logic [31:0] base, input int stallIdx);
    for (int i = 0; i < n; i++) begin
      iWriteDataValid = 1;
      iWriteData = base + 32'(i);
      iWriteEnable = (i % 2 == 1) ? 4'h3 : 4'hF;
      if (i == stallIdx) begin
        iDTL_WriteAccept = 0;
        tick();
      end
      iDTL_WriteAccept = 1;
      expW.push_back('{data: base + 32'(i), en: (i % 2 == 1) ? 4'h3 : 4'hF, last: (i == total - 1)});
      tick();
    end
    iWriteDataValid = 0;
    iDTL_WriteAccept = 0;
  endtask

  // Return n read beats; DTL ReadLast is on the true last beat unless badIdx >= 0
  task automatic readBeats(input int n, input logic [31:0] base, input int badIdx);
    iReadAccept = 1;
    for (int i = 0; i < n; i++) begin
      iDTL_ReadValid = 1;
      iDTL_ReadData = base + 32'(i);
      iDTL_ReadLast = (badIdx >= 0) ? (i == badIdx) : (i == n - 1);
      expR.push_back('{data: base + 32'(i), last: (i == n - 1)});
      tick();
    end
    iDTL_ReadValid = 0;
    iDTL_ReadLast = 0;
    iReadAccept = 0;
  endtask

  initial begin
    int acc0;
    iReset = 1;
    idleInputs();
    doReset();

    // Single read, blocksize 0: command appears two edges after the request
    sendReq(1'b0, 32'h100, 5'd0);
    check("lat_n1_cmdvalid", {63'd0, oDTL_CommandValid}, 64'd0);
    tick();
    check("lat_n2_cmdvalid", {63'd0, oDTL_CommandValid}, 64'd1);
    acceptCmd();
    readBeats(1, 32'hDEADBEEF, -1);
    check("t1_busy_after", {63'd0, oBusy}, 64'd0);

    // Write burst of 4 with a stall on beat 2
    acc0 = wAccepts;
    sendReq(1'b1, 32'h200, 5'd3);
    acceptCmd();
    writeBeats(4, 4, 32'd1, 1);
    check("t2_accept_count", 64'(wAccepts - acc0), 64'd4);
    check("t2_busy_after", {63'd0, oBusy}, 64'd0);

    // Fill the queue while commands are stalled: the head sits in the command
    // registers, so four more fit before oReqAccept drops
    sendReq(1'b1, 32'h300, 5'd1);
    sendReq(1'b0, 32'h400, 5'd0);
    sendReq(1'b0, 32'h500, 5'd2);
    sendReq(1'b1, 32'h600, 5'd0);
    sendReq(1'b0, 32'h680, 5'd1);
    iReqValid = 1; iReqWrite = 1; iReqAddress = 32'hBAD0; iReqBlockSize = 5'd0;
    check("t3_full_reqaccept", {63'd0, oReqAccept}, 64'd0);
    tick();
    iReqValid = 0;
    check("t3_busy", {63'd0, oBusy}, 64'd1);
    acceptCmd(); writeBeats(2, 2, 32'h30, -1);
    check("t3_gap_a", {63'd0, oDTL_CommandValid}, 64'd1);
    acceptCmd(); readBeats(1, 32'h40, -1);
    check("t3_gap_b", {63'd0, oDTL_CommandValid}, 64'd1);
    acceptCmd(); readBeats(3, 32'h50, -1);
    check("t3_gap_c", {63'd0, oDTL_CommandValid}, 64'd1);
    acceptCmd(); writeBeats(1, 1, 32'h60, -1);
    check("t3_gap_d", {63'd0, oDTL_CommandValid}, 64'd1);
    acceptCmd(); readBeats(2, 32'h68, -1);
    check("t3_busy_after", {63'd0, oBusy}, 64'd0);

    // Read of 3 with ReadLast on beat 1: error sticks, burst runs on the counter
    check("t4_perr_before", {63'd0, oProtocolError}, 64'd0);
    sendReq(1'b0, 32'h700, 5'd2);
    acceptCmd();
    readBeats(3, 32'h7000, 0);
    check("t4_perr_set", {63'd0, oProtocolError}, 64'd1);
    check("t4_busy_after", {63'd0, oBusy}, 64'd0);
    tick(); tick();
    check("t4_perr_sticky", {63'd0, oProtocolError}, 64'd1);

    // Maximum burst: 32 beats, last only on beat 32
    doReset();
    sendReq(1'b0, 32'h800, 5'd31);
    acceptCmd();
    readBeats(32, 32'h8000, -1);
    check("t5_perr", {63'd0, oProtocolError}, 64'd0);
    check("t5_busy_after", {63'd0, oBusy}, 64'd0);

    // Reset in the middle of a write burst with two entries queued
    sendReq(1'b1, 32'h900, 5'd3);
    sendReq(1'b1, 32'hA00, 5'd1);
    sendReq(1'b1, 32'hB00, 5'd0);
    acceptCmd();
    writeBeats(2, 4, 32'h90, -1);
    iReset = 1;
    iWriteDataValid = 1;
    iWriteData = 32'hFFFF;
    tick();
    iDTL_WriteAccept = 1;
    #1;
    expCmd.delete();
    expW.delete();
    check("t6_busy", {63'd0, oBusy}, 64'd0);
    check("t6_reqaccept", {63'd0, oReqAccept}, 64'd1);
    check("t6_cmdvalid", {63'd0, oDTL_CommandValid}, 64'd0);
    check("t6_wvalid", {63'd0, oDTL_WriteValid}, 64'd0);
    check("t6_waccept", {63'd0, oWriteDataAccept}, 64'd0);
    check("t6_rvalid", {63'd0, oReadDataValid}, 64'd0);
    check("t6_perr", {63'd0, oProtocolError}, 64'd0);
    iReset = 0;
    idleInputs();
    tick(); tick();
    check("t6_still_idle", {63'd0, oBusy}, 64'd0);

    check("left_cmd", 64'(expCmd.size()), 64'd0);
    check("left_wbeats", 64'(expW.size()), 64'd0);
    check("left_rbeats", 64'(expR.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
